// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : Per-channel synchroniser, debounce filter, press/release pulses,
//            long-press hold flag and (with BTN_REPEAT_EN) auto-repeat train.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
   parameter int BTN_NUM      = 3,
   parameter int DB_LIMIT     = 1_000_000,
   parameter int HOLD_LIMIT   = 50_000_000,
   parameter int REPEAT_LIMIT = 10_000_000
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [BTN_NUM-1:0] btn_raw,
   output logic [BTN_NUM-1:0] btn_level,
   output logic [BTN_NUM-1:0] btn_press,
   output logic [BTN_NUM-1:0] btn_release,
   output logic [BTN_NUM-1:0] btn_hold,
   output logic [BTN_NUM-1:0] btn_repeat
);

   localparam int DB_W   = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
   localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_LIMIT - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_LIMIT - 1);

`ifdef BTN_REPEAT_EN
   localparam int REP_W = (REPEAT_LIMIT > 1) ? $clog2(REPEAT_LIMIT) : 1;
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_LIMIT - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } btn_state_t;

   if (DB_LIMIT < 1 || HOLD_LIMIT < 1 || REPEAT_LIMIT < 1) begin : g_param_check
      $error("btn_conditioner: DB_LIMIT, HOLD_LIMIT and REPEAT_LIMIT must be >= 1");
   end

   for (genvar i = 0; i < BTN_NUM; i++) begin : g_ch
      logic              sync1_q, sync2_q;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      btn_state_t        state_q, state_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              level_cur;
      logic              flip;

      always_ff @(posedge sys_clk) begin
         if (!sys_rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
         end else begin
            sync1_q    <= btn_raw[i];
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            press_q    <= press_d;
            release_q  <= release_d;
         end
      end

      // The filter counts consecutive disagreeing samples; the flip itself is
      // taken by the state machine so level, press and release move together.
      always_comb begin
         level_cur  = (state_q != ST_IDLE);
         flip       = 1'b0;
         db_cnt_d   = '0;
         hold_cnt_d = '0;
         state_d    = state_q;
         press_d    = 1'b0;
         release_d  = 1'b0;

         if (sync2_q != level_cur) begin
            if (db_cnt_q == DB_MAX) begin
               flip = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (flip) begin
                  state_d = ST_PRESSED;
                  press_d = 1'b1;
               end
            end
            ST_PRESSED: begin
               if (flip) begin
                  state_d   = ST_IDLE;
                  release_d = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
                  if (hold_cnt_q == HOLD_PRE) begin
                     state_d = ST_HELD;
                  end
               end
            end
            ST_HELD: begin
               if (flip) begin
                  state_d   = ST_IDLE;
                  release_d = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      assign btn_level[i]   = (state_q != ST_IDLE);
      assign btn_hold[i]    = (state_q == ST_HELD);
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;

`ifdef BTN_REPEAT_EN
      logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
      logic             rep_q, rep_d;

      always_ff @(posedge sys_clk) begin
         if (!sys_rst_n) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
         end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
         end
      end

      // Gating on the next state keeps the release cycle free of pulses.
      always_comb begin
         rep_cnt_d = '0;
         rep_d     = 1'b0;
         if (state_d == ST_HELD) begin
            if (state_q != ST_HELD) begin
               rep_d = 1'b1;
            end else if (rep_cnt_q == REP_MAX) begin
               rep_d = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end
      end

      assign btn_repeat[i] = rep_q;
`else
      assign btn_repeat[i] = 1'b0;
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Directed + randomized bench for btn_conditioner with an
//            edge-history reference model (BTN_REPEAT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

   localparam int NB    = 3;
   localparam int DBL   = 4;
   localparam int HOLD  = 10;
   localparam int REPL  = 5;
   localparam int MAXE  = 8192;
`ifdef BTN_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;

   int n_tests = 0;
   int n_fail  = 0;

   btn_conditioner #(
      .BTN_NUM      (NB),
      .DB_LIMIT     (DBL),
      .HOLD_LIMIT   (HOLD),
      .REPEAT_LIMIT (REPL)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_hold    (btn_hold),
      .btn_repeat  (btn_repeat)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: decisions from raw-sample history ----------------
   logic [NB-1:0] raw_at [MAXE];
   int            n = -1;
   int            last_rst = 0;
   bit            lvl [NB];
   int            pe  [NB];
   logic [NB-1:0] e_lvl, e_prs, e_rel, e_hld, e_rep;

   // Filter input seen at edge m is the raw value from two edges earlier,
   // forced low while the synchroniser is still flushing after reset.
   function automatic bit filt_in(input int ch, input int m);
      if (m - 2 > last_rst) return raw_at[m-2][ch];
      return 1'b0;
   endfunction

   initial begin : model_proc
      bit flip;
      forever begin
         @(posedge sys_clk);
         #1;
         n++;
         if (n < MAXE) raw_at[n] = btn_raw;
         if (!sys_rst_n) begin
            last_rst = n;
            for (int ch = 0; ch < NB; ch++) lvl[ch] = 1'b0;
            e_lvl = '0; e_prs = '0; e_rel = '0; e_hld = '0; e_rep = '0;
         end else begin
            for (int ch = 0; ch < NB; ch++) begin
               flip = 1'b1;
               for (int k = 0; k < DBL; k++) begin
                  if ((n - k) <= last_rst || filt_in(ch, n - k) == lvl[ch]) flip = 1'b0;
               end
               e_prs[ch] = flip & ~lvl[ch];
               e_rel[ch] = flip & lvl[ch];
               if (flip) lvl[ch] = ~lvl[ch];
               if (e_prs[ch]) pe[ch] = n;
               e_lvl[ch] = lvl[ch];
               e_hld[ch] = lvl[ch] && ((n - pe[ch]) >= HOLD);
               e_rep[ch] = REP_ON && e_hld[ch] && (((n - pe[ch] - HOLD) % REPL) == 0);
            end
         end
         chk("cycle_model",
             {17'd0, btn_level, btn_press, btn_release, btn_hold, btn_repeat},
             {17'd0, e_lvl, e_prs, e_rel, e_hld, e_rep});
      end
   end

   // ---------------- stimulus with literal spot checks ----------------
   int e;

   task automatic step();
      @(posedge sys_clk);
      #1;
      e++;
   endtask

   task automatic run_to(input int tgt);
      while (e < tgt) step();
   endtask

   task automatic drive(input logic [NB-1:0] raw);
      @(negedge sys_clk);
      btn_raw = raw;
      e = -1;
   endtask

   task automatic idle(input int k);
      @(negedge sys_clk);
      e = -1;
      run_to(k - 1);
   endtask

   initial begin : stim_proc
      int run [NB];
      sys_rst_n = 1'b0;
      btn_raw   = '0;
      e = -1;
      run_to(2);
      chk("reset_outputs", {17'd0, btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle(4);

      // single press on ch0, hold, repeat train, release
      drive(3'b001);
      run_to(4);  chk("lvl_before_E5", btn_level, 3'b000);
      run_to(5);  chk("press_E5", btn_press, 3'b001);
                  chk("level_E5", btn_level, 3'b001);
      run_to(6);  chk("press_low_E6", btn_press, 3'b000);
      run_to(14); chk("hold_low_E14", btn_hold, 3'b000);
      run_to(15); chk("hold_E15", btn_hold, 3'b001);
                  chk("rep_E15", btn_repeat, REP_ON ? 3'b001 : 3'b000);
      run_to(16); chk("rep_low_E16", btn_repeat, 3'b000);
      run_to(20); chk("rep_E20", btn_repeat, REP_ON ? 3'b001 : 3'b000);
      run_to(24);
      @(negedge sys_clk);
      btn_raw = 3'b000;
      run_to(25); chk("rep_E25", btn_repeat, REP_ON ? 3'b001 : 3'b000);
      run_to(29); chk("level_still_E29", btn_level, 3'b001);
      run_to(30); chk("release_E30", btn_release, 3'b001);
                  chk("rel_lvl_hold_E30", {btn_level, btn_hold}, 6'b000000);
                  chk("no_rep_in_release", btn_repeat, 3'b000);
      run_to(31); chk("release_low_E31", btn_release, 3'b000);
      idle(6);

      // ch1 glitch of DB_LIMIT-1 cycles is filtered out
      drive(3'b010);
      run_to(2);
      @(negedge sys_clk);
      btn_raw = 3'b000;
      run_to(5);  chk("glitch_lvl_E5", btn_level, 3'b000);
      run_to(10); chk("glitch_edges_E10", {btn_press, btn_release}, 6'b000000);

      // ch2 high for exactly DB_LIMIT cycles still flips
      drive(3'b100);
      run_to(3);
      @(negedge sys_clk);
      btn_raw = 3'b000;
      run_to(5);  chk("boundary_press_E5", btn_press, 3'b100);
      run_to(9);  chk("boundary_release_E9", btn_release, 3'b100);
      idle(6);

      // reset during hold, raw kept high
      drive(3'b001);
      run_to(16); chk("hold_before_rst", btn_hold, 3'b001);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      run_to(17); chk("rst_midhold_all0", {17'd0, btn_level, btn_press, btn_release, btn_hold, btn_repeat}, 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      run_to(22); chk("no_press_E22", btn_press, 3'b000);
      run_to(23); chk("repress_E23", btn_press, 3'b001);
      drive(3'b000);
      idle(10);

      // all channels together
      drive(3'b111);
      run_to(5);  chk("all_press_E5", btn_press, 3'b111);
      run_to(15); chk("all_hold_E15", btn_hold, 3'b111);
                  chk("all_rep_E15", btn_repeat, REP_ON ? 3'b111 : 3'b000);
      drive(3'b000);
      idle(10);

      // randomized phase, checked only by the model
      for (int ch = 0; ch < NB; ch++) run[ch] = 1;
      repeat (3000) begin
         @(negedge sys_clk);
         if (!sys_rst_n) sys_rst_n = 1'b1;
         else if ($urandom_range(0, 499) == 0) sys_rst_n = 1'b0;
         for (int ch = 0; ch < NB; ch++) begin
            run[ch]--;
            if (run[ch] <= 0) begin
               btn_raw[ch] = ~btn_raw[ch];
               run[ch] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 6))
                                                    : int'($urandom_range(5, 40));
            end
         end
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      btn_raw = '0;
      repeat (20) @(negedge sys_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
